dm_access_unit: RTL and testbench

- Multi-cycle data-memory access unit between the CPU MEM stage and a synchronous word-wide data RAM with configurable read latency.
- Handles word, halfword and byte loads/stores using the existing DMType encoding, generates byte write enables, and returns sign/zero-extended load data.
- Uses a valid/ready request and response-pulse protocol.
- Flags illegal accesses, or splits word-crossing accesses into two RAM beats when the optional feature is compiled in.

---
 rtl/dm_access_unit.sv | 269 ++++++++++++++++++++++++++
 tb/tb_dm_access_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_access_unit.sv
// Multi-cycle data-memory access unit: byte/half/word loads and stores onto a word-wide RAM.
// Optional macro DM_MISALIGN_SPLIT_EN: misaligned half/word allowed, word-crossing accesses take two beats.
module dm_access_unit #(
    parameter int ADDR_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_type,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault,
    output logic              mem_en,
    output logic [3:0]        mem_wea,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

`ifdef DM_MISALIGN_SPLIT_EN
    localparam int LANES = 8;
`else
    localparam int LANES = 4;
`endif
    localparam int LANE_BITS = 8 * LANES;
    localparam int WA_W      = ADDR_W - 2;
    localparam logic [2:0] LAT = 3'(RD_LATENCY);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BEAT0 = 3'd1,
        WAIT0 = 3'd2,
        BEAT1 = 3'd3,
        WAIT1 = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t state, state_nxt;
    logic [2:0] cnt, cnt_nxt;

    logic                 accept;
    logic [2:0]           size_req;
    logic [1:0]           off_req;
    logic [LANES-1:0]     ones_req;
    logic [LANES-1:0]     mask_req;
    logic [LANE_BITS-1:0] lane_req;
    logic                 misalign_req;
    logic                 fault_req;

    logic [WA_W-1:0] addr_q;
    logic [1:0]      off_q;
    logic [2:0]      type_q;
    logic            we_q;
`ifdef DM_MISALIGN_SPLIT_EN
    logic            cross_q;
    logic [3:0]      mask_hi_q;
    logic [31:0]     lane_hi_q;
    logic [31:0]     lo_q;
`endif

    logic [LANE_BITS-1:0] pair;
    logic            mem_en_nxt;
    logic [3:0]      mem_wea_nxt;
    logic [WA_W-1:0] mem_addr_nxt;
    logic [31:0]     mem_wdata_nxt;
    logic            rsp_valid_nxt;
    logic            rsp_fault_nxt;
    logic [31:0]     rsp_rdata_nxt;

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] typ);
        logic signed [15:0] half_s;
        logic signed [7:0]  byte_s;
        logic signed [31:0] ext_s;
        half_s = word[15:0];
        byte_s = word[7:0];
        ext_s  = $signed(word);
        case (typ)
            3'b001:  ext_s = 32'(half_s);
            3'b010:  ext_s = $signed({16'd0, word[15:0]});
            3'b011:  ext_s = 32'(byte_s);
            3'b100:  ext_s = $signed({24'd0, word[7:0]});
            default: ext_s = $signed(word);
        endcase
        return ext_s;
    endfunction

    // Realign the captured beat(s) so the addressed byte sits at bit 0, then extend.
    function automatic logic [31:0] align_load(input logic [LANE_BITS-1:0] words,
                                               input logic [1:0] off,
                                               input logic [2:0] typ);
        logic [31:0] word;
        word = 32'(words >> {off, 3'b000});
        return load_extend(word, typ);
    endfunction

    assign req_ready = (state == IDLE) || (state == DONE);
    assign accept    = req_valid && req_ready;
    assign off_req   = req_addr[1:0];

    always_comb begin
        size_req = 3'd1;
        case (req_type)
            3'b000:         size_req = 3'd4;
            3'b001, 3'b010: size_req = 3'd2;
            default:        size_req = 3'd1;
        endcase
        ones_req = (LANES'(1) << size_req) - LANES'(1);
        mask_req = ones_req << off_req;
        lane_req = LANE_BITS'(req_wdata) << {off_req, 3'b000};
    end

`ifdef DM_MISALIGN_SPLIT_EN
    assign misalign_req = 1'b0;
`else
    assign misalign_req = ((req_type == 3'b000) && (off_req != 2'b00)) ||
                          (((req_type == 3'b001) || (req_type == 3'b010)) && off_req[0]);
`endif
    assign fault_req = (req_type > 3'b100) || misalign_req;

    // Word pair seen by the final capture: current RAM data as hi for split loads.
    always_comb begin
`ifdef DM_MISALIGN_SPLIT_EN
        pair = (state == WAIT1) ? {mem_rdata, lo_q} : {32'd0, mem_rdata};
`else
        pair = mem_rdata;
`endif
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        mem_en_nxt    = 1'b0;
        mem_wea_nxt   = 4'b0000;
        mem_addr_nxt  = '0;
        mem_wdata_nxt = 32'd0;
        rsp_valid_nxt = 1'b0;
        rsp_fault_nxt = 1'b0;
        rsp_rdata_nxt = 32'd0;
        case (state)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (req_valid) begin
                    if (fault_req) begin
                        state_nxt     = DONE;
                        rsp_valid_nxt = 1'b1;
                        rsp_fault_nxt = 1'b1;
                    end else begin
                        state_nxt    = BEAT0;
                        mem_en_nxt   = 1'b1;
                        mem_addr_nxt = req_addr[ADDR_W-1:2];
                        if (req_we) begin
                            mem_wea_nxt   = mask_req[3:0];
                            mem_wdata_nxt = lane_req[31:0];
                        end
                    end
                end
            end
            BEAT0: begin
                if (we_q) begin
`ifdef DM_MISALIGN_SPLIT_EN
                    if (cross_q) begin
                        state_nxt     = BEAT1;
                        mem_en_nxt    = 1'b1;
                        mem_addr_nxt  = addr_q + WA_W'(1);
                        mem_wea_nxt   = mask_hi_q;
                        mem_wdata_nxt = lane_hi_q;
                    end else
`endif
                    begin
                        state_nxt     = DONE;
                        rsp_valid_nxt = 1'b1;
                    end
                end else begin
                    state_nxt = WAIT0;
                    cnt_nxt   = 3'd1;
                end
            end
            WAIT0: begin
                if (cnt == LAT) begin
`ifdef DM_MISALIGN_SPLIT_EN
                    if (cross_q) begin
                        state_nxt    = BEAT1;
                        mem_en_nxt   = 1'b1;
                        mem_addr_nxt = addr_q + WA_W'(1);
                    end else
`endif
                    begin
                        state_nxt     = DONE;
                        rsp_valid_nxt = 1'b1;
                        rsp_rdata_nxt = align_load(pair, off_q, type_q);
                    end
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
            end
`ifdef DM_MISALIGN_SPLIT_EN
            BEAT1: begin
                if (we_q) begin
                    state_nxt     = DONE;
                    rsp_valid_nxt = 1'b1;
                end else begin
                    state_nxt = WAIT1;
                    cnt_nxt   = 3'd1;
                end
            end
            WAIT1: begin
                if (cnt == LAT) begin
                    state_nxt     = DONE;
                    rsp_valid_nxt = 1'b1;
                    rsp_rdata_nxt = align_load(pair, off_q, type_q);
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            mem_en    <= 1'b0;
            mem_wea   <= 4'b0000;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_fault <= 1'b0;
            rsp_rdata <= 32'd0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            mem_en    <= mem_en_nxt;
            mem_wea   <= mem_wea_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_fault <= rsp_fault_nxt;
            rsp_rdata <= rsp_rdata_nxt;
        end
    end

    // Request fields are held here for the rest of the access.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q    <= req_addr[ADDR_W-1:2];
            off_q     <= off_req;
            type_q    <= req_type;
            we_q      <= req_we;
`ifdef DM_MISALIGN_SPLIT_EN
            cross_q   <= |mask_req[7:4];
            mask_hi_q <= mask_req[7:4];
            lane_hi_q <= lane_req[63:32];
`endif
        end
`ifdef DM_MISALIGN_SPLIT_EN
        if ((state == WAIT0) && (cnt == LAT)) begin
            lo_q <= mem_rdata;
        end
`endif
    end

endmodule

// File: tb/tb_dm_access_unit.sv
// Self-checking bench for dm_access_unit: byte-level reference model plus a latency-accurate RAM.
module tb_dm_access_unit;
    localparam int TB_LAT = 2;
`ifdef DM_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_type;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic        mem_en;
    logic [3:0]  mem_wea;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dm_access_unit #(.ADDR_W(32), .RD_LATENCY(TB_LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_type(req_type),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
        .mem_en(mem_en), .mem_wea(mem_wea), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Sparse RAM: every word the bench touches maps to a distinct slot.
    function automatic logic [7:0] key(input logic [29:0] w);
        return {w[29], w[6:0]};
    endfunction

    logic [31:0] ram [256];
    logic [31:0] rd_pipe [TB_LAT];

    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_wea[b]) ram[key(mem_addr)][8*b +: 8] <= mem_wdata[8*b +: 8];
            rd_pipe[0] <= (mem_wea == 4'b0000) ? ram[key(mem_addr)] : $urandom;
        end else begin
            rd_pipe[0] <= $urandom;
        end
        for (int i = 1; i < TB_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[TB_LAT-1];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] t);
        case (t)
            3'b000:         return 4;
            3'b001, 3'b010: return 2;
            default:        return 1;
        endcase
    endfunction

    function automatic logic [31:0] byte_mask(input logic [3:0] w);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{w[b]}};
        return m;
    endfunction

    // One transaction, started on a negedge; returns on the negedge of the response cycle.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] typ, output logic [31:0] got);
        int sz, nb, exp_rsp, k, rsp_n;
        bit flt, crs, idle_bad;
        logic [29:0] bw [2];
        logic [3:0]  bwea [2];
        logic [31:0] bdata [2];
        int          bcyc [2];
        logic [31:0] ld, exp_data;
        logic [29:0] ob_addr [2];
        logic [3:0]  ob_wea [2];
        logic [31:0] ob_wd [2];
        int          ob_cyc [2];
        logic        o_fault;
        logic [31:0] o_data;

        sz  = size_of(typ);
        flt = (typ > 3'b100) ||
              (!SPLIT && ((sz == 4 && addr[1:0] != 2'b00) || (sz == 2 && addr[0])));
        bw[0] = addr[31:2];
        bw[1] = addr[31:2] + 30'd1;
        bwea[0] = 4'b0; bwea[1] = 4'b0;
        bdata[0] = 32'd0; bdata[1] = 32'd0;
        crs = 1'b0;
        ld  = 32'd0;
        for (int i = 0; i < sz; i++) begin
            logic [31:0] ba;
            int b;
            ba = addr + 32'(i);
            b  = (ba[31:2] == bw[0]) ? 0 : 1;
            if (b == 1) crs = 1'b1;
            bwea[b][ba[1:0]] = 1'b1;
            bdata[b][8*ba[1:0] +: 8] = wdata[8*i +: 8];
            ld[8*i +: 8] = ram[key(ba[31:2])][8*ba[1:0] +: 8];
        end
        case (typ)
            3'b000:  exp_data = ld;
            3'b001:  exp_data = {{16{ld[15]}}, ld[15:0]};
            3'b010:  exp_data = {16'd0, ld[15:0]};
            3'b011:  exp_data = {{24{ld[7]}}, ld[7:0]};
            default: exp_data = {24'd0, ld[7:0]};
        endcase
        if (flt || we) exp_data = 32'd0;
        nb = flt ? 0 : (crs ? 2 : 1);
        bcyc[0] = 1;
        bcyc[1] = we ? 2 : TB_LAT + 2;
        if (flt)          exp_rsp = 1;
        else if (we)      exp_rsp = 1 + nb;
        else if (nb == 1) exp_rsp = TB_LAT + 2;
        else              exp_rsp = 2 * TB_LAT + 3;

        check("req_ready", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_type = typ;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'($urandom_range(0, 1)); req_addr = $urandom;
        req_wdata = $urandom; req_type = 3'($urandom_range(0, 7));

        k = 0; rsp_n = 0; idle_bad = 1'b0; o_fault = 1'b0; o_data = 32'd0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (mem_en) begin
                if (k < 2) begin
                    ob_addr[k] = mem_addr; ob_wea[k] = mem_wea;
                    ob_wd[k] = mem_wdata; ob_cyc[k] = n;
                end
                k++;
            end else if (mem_wea != 4'b0 || mem_addr != 30'd0 || mem_wdata != 32'd0) begin
                idle_bad = 1'b1;
            end
            if (rsp_valid) begin
                rsp_n = n; o_fault = rsp_fault; o_data = rsp_rdata;
                break;
            end
        end
        got = o_data;

        check("rsp_latency", 64'(rsp_n), 64'(exp_rsp));
        check("rsp_fault", 64'(o_fault), 64'(flt));
        check("rsp_rdata", 64'(o_data), 64'(exp_data));
        check("beat_count", 64'(k), 64'(nb));
        check("mem_idle_zero", 64'(idle_bad), 64'd0);
        for (int b = 0; b < nb && b < k; b++) begin
            check("beat_cycle", 64'(ob_cyc[b]), 64'(bcyc[b]));
            check("beat_addr", 64'(ob_addr[b]), 64'(bw[b]));
            check("beat_wea", 64'(ob_wea[b]), we ? 64'(bwea[b]) : 64'd0);
            if (we) check("beat_wdata", 64'(ob_wd[b] & byte_mask(bwea[b])), 64'(bdata[b]));
        end
    endtask

    task automatic idle_gap(input int n);
        bit bad;
        bad = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (rsp_valid || mem_en) bad = 1'b1;
        end
        check("idle_quiet", 64'(bad), 64'd0);
    endtask

    initial begin
        logic [31:0] got;
        bit quiet;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0;
        req_wdata = 32'd0; req_type = 3'd0;
        repeat (2) @(negedge clk);
        check("reset_ready", 64'(req_ready), 64'd1);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_mem_en", 64'(mem_en), 64'd0);
        check("reset_mem_addr", 64'(mem_addr), 64'd0);
        rst = 1'b0;

        // Seed every RAM word the stimulus can reach.
        for (int w = 32'h3E; w <= 32'h44; w++) access(1'b1, 32'(w) << 2, $urandom, 3'b000, got);
        for (int w = 0; w <= 2; w++) access(1'b1, 32'(w) << 2, $urandom, 3'b000, got);
        access(1'b1, 32'hFFFF_FFF8, $urandom, 3'b000, got);
        access(1'b1, 32'hFFFF_FFFC, $urandom, 3'b000, got);

        access(1'b1, 32'h0000_0103, 32'h0000_00A5, 3'b011, got);
        access(1'b0, 32'h0000_0100, 32'd0, 3'b000, got);
        check("byte_store_lane", 64'(got[31:24]), 64'hA5);
        access(1'b1, 32'h0000_0100, 32'h8001_1234, 3'b000, got);
        access(1'b0, 32'h0000_0102, 32'd0, 3'b001, got);
        check("half_signed", 64'(got), 64'hFFFF_8001);
        access(1'b0, 32'h0000_0102, 32'd0, 3'b010, got);
        check("half_unsigned", 64'(got), 64'h0000_8001);
        access(1'b0, 32'h0000_0100, 32'd0, 3'b101, got);
        access(1'b0, 32'h0000_0101, 32'd0, 3'b000, got);
        access(1'b1, 32'h0000_00FE, 32'h1122_3344, 3'b000, got);
        access(1'b0, 32'hFFFF_FFFF, 32'd0, 3'b000, got);
        access(1'b0, 32'h0000_00FC, 32'd0, 3'b000, got);

        for (int t = 0; t < 150; t++) begin
            logic [31:0] a;
            logic [2:0]  ty;
            case ($urandom_range(0, 3))
                0:       a = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
                1:       a = 32'($urandom_range(0, 7));
                default: a = 32'h0000_00F8 + 32'($urandom_range(0, 23));
            endcase
            ty = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            access(1'($urandom_range(0, 1)), a, $urandom, ty, got);
            if ($urandom_range(0, 4) == 0) idle_gap($urandom_range(1, 3));
        end

        // Reset while a load is waiting on RAM data.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0100; req_type = 3'b000;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_ready", 64'(req_ready), 64'd1);
        check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("midrst_rsp_fault", 64'(rsp_fault), 64'd0);
        check("midrst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("midrst_mem_en", 64'(mem_en), 64'd0);
        check("midrst_mem_wea", 64'(mem_wea), 64'd0);
        check("midrst_mem_addr", 64'(mem_addr), 64'd0);
        check("midrst_mem_wdata", 64'(mem_wdata), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        quiet = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid || mem_en) quiet = 1'b0;
        end
        check("midrst_no_rsp", 64'(quiet), 64'd1);
        access(1'b0, 32'h0000_0100, 32'd0, 3'b000, got);
        access(1'b1, 32'h0000_0104, 32'hCAFE_F00D, 3'b000, got);
        idle_gap(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
